// File: rtl/fsk_tx_mod.sv
// Continuous-phase binary FSK modulator: serialises 16-bit words MSB-first
// into a signed sine sample stream, one sample every CLK_PER_SAMPLE cycles.
module fsk_tx_mod #(
  parameter int          CLK_PER_SAMPLE  = 4,
  parameter int          SAMPLES_PER_BIT = 64,
  parameter int          GUARD_SAMPLES   = 16,
  parameter logic [15:0] INC0            = 16'h0400,
  parameter logic [15:0] INC1            = 16'h0800
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [15:0] sig_to_dac,
  output logic        dac_strobe,
  output logic        bit_out,
  output logic        busy
);

  localparam int DIV_W = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_PER_SAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [15:0]      SPB_LAST   = 16'(SAMPLES_PER_BIT - 1);
  localparam logic [15:0]      GUARD_LAST = 16'(GUARD_SAMPLES - 1);
  localparam bit               HAS_GUARD  = (GUARD_SAMPLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_r;
  logic [15:0]        sample_cnt_r;
  logic [3:0]         bit_cnt_r;
  logic [15:0]        guard_cnt_r;
  logic [15:0]        shift_r;
  logic [15:0]        phase_r;
  logic               tick_s;

  // Quarter-wave table mirrored into a full 64-entry period.
  function automatic logic [15:0] sine_lut(input logic [5:0] idx);
    logic [4:0]  q_idx;
    logic [15:0] mag;
    q_idx = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    case (q_idx)
      5'd0:    mag = 16'd0;
      5'd1:    mag = 16'd3212;
      5'd2:    mag = 16'd6393;
      5'd3:    mag = 16'd9512;
      5'd4:    mag = 16'd12539;
      5'd5:    mag = 16'd15446;
      5'd6:    mag = 16'd18204;
      5'd7:    mag = 16'd20787;
      5'd8:    mag = 16'd23170;
      5'd9:    mag = 16'd25329;
      5'd10:   mag = 16'd27245;
      5'd11:   mag = 16'd28898;
      5'd12:   mag = 16'd30273;
      5'd13:   mag = 16'd31356;
      5'd14:   mag = 16'd32137;
      5'd15:   mag = 16'd32609;
      5'd16:   mag = 16'd32767;
      default: mag = 16'd0;
    endcase
    return idx[5] ? (16'd0 - mag) : mag;
  endfunction

  assign tick_s = (div_r == DIV_LAST);

  // Frame sequencer: handshake, sample divider, modulation and guard tail.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      div_r        <= '0;
      sample_cnt_r <= 16'd0;
      bit_cnt_r    <= 4'd0;
      guard_cnt_r  <= 16'd0;
      shift_r      <= 16'd0;
      phase_r      <= 16'd0;
      data_ready   <= 1'b0;
      sig_to_dac   <= 16'd0;
      dac_strobe   <= 1'b0;
      bit_out      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dac_strobe <= 1'b0;
      case (state_r)
        IDLE: begin
          data_ready <= 1'b1;
          busy       <= 1'b0;
          bit_out    <= 1'b0;
          if (data_valid && data_ready) begin
            shift_r      <= data_in;
            phase_r      <= 16'd0;
            div_r        <= '0;
            sample_cnt_r <= 16'd0;
            bit_cnt_r    <= 4'd0;
            guard_cnt_r  <= 16'd0;
            bit_out      <= data_in[15];
            busy         <= 1'b1;
            data_ready   <= 1'b0;
            state_r      <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          div_r <= tick_s ? '0 : div_r + DIV_ONE;
          if (tick_s) begin
            dac_strobe <= 1'b1;
            sig_to_dac <= sine_lut(phase_r[15:10]);
            phase_r    <= phase_r + (shift_r[15] ? INC1 : INC0);
            if (sample_cnt_r == SPB_LAST) begin
              sample_cnt_r <= 16'd0;
              shift_r      <= {shift_r[14:0], 1'b0};
              bit_cnt_r    <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd15) begin
                bit_out <= 1'b0;
                // Without a guard tail the frame ends on the last data sample.
                if (HAS_GUARD) begin
                  state_r <= GUARD;
                end else begin
                  state_r    <= IDLE;
                  busy       <= 1'b0;
                  data_ready <= 1'b1;
                end
              end else begin
                bit_out <= shift_r[14];
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + 16'd1;
            end
          end else begin
            sample_cnt_r <= sample_cnt_r;
          end
        end
        GUARD: begin
          div_r <= tick_s ? '0 : div_r + DIV_ONE;
          if (tick_s) begin
            dac_strobe <= 1'b1;
            sig_to_dac <= 16'd0;
            if (guard_cnt_r == GUARD_LAST) begin
              state_r    <= IDLE;
              busy       <= 1'b0;
              data_ready <= 1'b1;
            end else begin
              guard_cnt_r <= guard_cnt_r + 16'd1;
            end
          end else begin
            guard_cnt_r <= guard_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_mod.sv
// Scoreboarded bench for fsk_tx_mod: a default instance and a fast,
// guard-less instance with a non-wrapping INC0, both checked against a sine model.
module tb_fsk_tx_mod;

  typedef struct {
    int s;
    logic b;
    int t;
  } item_t;

  logic        sysclk;
  logic        reset;
  logic [15:0] din  [2];
  logic        dv   [2];
  logic        rdy  [2];
  logic [15:0] sig  [2];
  logic        stb  [2];
  logic        bout [2];
  logic        bsy  [2];

  int cps  [2] = '{4, 3};
  int spb  [2] = '{64, 8};
  int grd  [2] = '{16, 0};
  int inc0 [2] = '{16'h0400, 16'h0500};
  int inc1 [2] = '{16'h0800, 16'h0B00};

  item_t exq [2][$];
  int    fstart [2] = '{0, 0};
  int    fend   [2] = '{0, 0};
  logic  first_b [2];
  logic  last_b  [2];
  int    cyc = 0;
  bit    chk_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  fsk_tx_mod dut_a (
    .sysclk(sysclk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .sig_to_dac(sig[0]), .dac_strobe(stb[0]),
    .bit_out(bout[0]), .busy(bsy[0])
  );

  fsk_tx_mod #(
    .CLK_PER_SAMPLE(3), .SAMPLES_PER_BIT(8), .GUARD_SAMPLES(0),
    .INC0(16'h0500), .INC1(16'h0B00)
  ) dut_b (
    .sysclk(sysclk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .sig_to_dac(sig[1]), .dac_strobe(stb[1]),
    .bit_out(bout[1]), .busy(bsy[1])
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, exp_v);
    end
  endtask

  // Reference: every sample is sin of the accumulated phase, in real arithmetic.
  task automatic model(input int d, input logic [15:0] w, input int acc);
    int    n;
    int    ph;
    int    idx;
    logic  bitv;
    item_t it;
    n  = 16 * spb[d];
    ph = 0;
    for (int k = 0; k < n; k++) begin
      bitv = w[15 - k / spb[d]];
      idx  = ph / 1024;
      it.s = int'(32767.0 * $sin(6.283185307179586 * idx / 64.0));
      it.b = (k + 1 < n) ? w[15 - (k + 1) / spb[d]] : 1'b0;
      it.t = acc + cps[d] * (k + 1);
      exq[d].push_back(it);
      ph = (ph + (bitv ? inc1[d] : inc0[d])) % 65536;
    end
    for (int g = 0; g < grd[d]; g++) begin
      it.s = 0;
      it.b = 1'b0;
      it.t = acc + cps[d] * (n + g + 1);
      exq[d].push_back(it);
    end
    first_b[d] = w[15];
    fstart[d]  = acc;
    fend[d]    = acc + cps[d] * (n + grd[d]);
  endtask

  // Called at a falling edge; returns the cycle index of the accepting edge.
  task automatic send(input int d, input logic [15:0] w, input bit keep, output int acc);
    int lim;
    lim   = 0;
    acc   = -1;
    din[d] = w;
    dv[d]  = 1'b1;
    while (acc < 0 && lim < 20000) begin
      if (rdy[d]) begin
        acc = cyc + 1;
        model(d, w, acc);
      end
      @(negedge sysclk);
      lim++;
    end
    if (!keep) dv[d] = 1'b0;
    if (acc < 0) chk("accept_timeout", d, 0, 1);
  endtask

  task automatic wait_done(input int d);
    int lim;
    lim = 0;
    while ((exq[d].size() != 0 || cyc <= fend[d]) && lim < 20000) begin
      @(negedge sysclk);
      lim++;
    end
    chk("frame_drained", d, exq[d].size(), 0);
  endtask

  // Monitor: pops an expected sample on every strobe, tracks busy/ready/bit_out.
  always @(negedge sysclk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en) begin
        if (cyc == fstart[d]) last_b[d] = first_b[d];
        chk("busy", d, int'(bsy[d]), int'(cyc >= fstart[d] && cyc < fend[d]));
        chk("data_ready", d, int'(rdy[d]), int'(!(cyc >= fstart[d] && cyc < fend[d])));
        if (stb[d]) begin
          if (exq[d].size() == 0) begin
            chk("unexpected_strobe", d, 1, 0);
          end else begin
            item_t it;
            it = exq[d].pop_front();
            chk("sample", d, int'($signed(sig[d])), it.s);
            chk("strobe_time", d, cyc, it.t);
            chk("bit_after_tick", d, int'(bout[d]), int'(it.b));
            last_b[d] = it.b;
          end
        end
        chk("bit_out", d, int'(bout[d]), int'(last_b[d]));
      end else begin
        last_b[d] = 1'b0;
      end
    end
  end

  initial begin
    int a1, a2, b1, b2;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      din[d] = 16'h0000;
      dv[d]  = 1'b0;
    end
    repeat (8) @(posedge sysclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, int'(rdy[d]), 0);
      chk("rst_sig", d, int'(sig[d]), 0);
      chk("rst_strobe", d, int'(stb[d]), 0);
      chk("rst_busy", d, int'(bsy[d]), 0);
    end
    @(negedge sysclk);
    reset = 1'b0;
    @(posedge sysclk);
    #1;
    for (int d = 0; d < 2; d++) chk("ready_after_rst", d, int'(rdy[d]), 1);
    @(negedge sysclk);
    chk_en = 1'b1;

    fork
      begin
        send(0, 16'h0000, 1'b0, a1);
        wait_done(0);
        send(0, 16'h69C3, 1'b0, a1);
        wait_done(0);
        send(0, 16'hEFAB, 1'b1, a1);
        send(0, 16'hEFAB, 1'b0, a2);
        chk("accept_gap_a", 0, a2 - a1, 4160 + 1);
        wait_done(0);
        for (int i = 0; i < 2; i++) begin
          send(0, 16'($urandom_range(0, 65535)), 1'b0, a1);
          wait_done(0);
        end
      end
      begin
        send(1, 16'hFFFF, 1'b1, b1);
        send(1, 16'h0000, 1'b0, b2);
        chk("accept_gap_b", 1, b2 - b1, 384 + 1);
        for (int i = 0; i < 12; i++) send(1, 16'($urandom_range(0, 65535)), 1'b0, b1);
        wait_done(1);
      end
    join

    // Abort a frame mid-flight, then transmit again from phase 0.
    send(0, 16'($urandom_range(0, 65535)), 1'b0, a1);
    repeat (1025) @(posedge sysclk);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("abort_ready", 0, int'(rdy[0]), 0);
    chk("abort_sig", 0, int'(sig[0]), 0);
    chk("abort_strobe", 0, int'(stb[0]), 0);
    chk("abort_bit", 0, int'(bout[0]), 0);
    chk("abort_busy", 0, int'(bsy[0]), 0);
    for (int d = 0; d < 2; d++) begin
      exq[d].delete();
      fstart[d] = 0;
      fend[d]   = 0;
    end
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(posedge sysclk);
    #1;
    chk("ready_after_abort", 0, int'(rdy[0]), 1);
    @(negedge sysclk);
    chk_en = 1'b1;
    fork
      begin
        send(0, 16'hA55A, 1'b0, a1);
        wait_done(0);
      end
      begin
        send(1, 16'h3C96, 1'b0, b1);
        wait_done(1);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_tx_mod.md
# fsk_tx_mod

Continuous-phase binary FSK modulator: the transmit-side counterpart of the FSK receive chain (fsk_top_mod) that consumes `sig_from_adc`. It accepts 16-bit words over a valid/ready handshake, serialises them MSB-first, and emits a signed 16-bit sine sample stream for a DAC. Bit value 0 selects tone F0 and bit value 1 selects tone F1. The sample rate is `sysclk` divided down, and the phase is continuous across bit boundaries.

## Interface
Parameters:
- `CLK_PER_SAMPLE`, default 4: sysclk cycles per output sample. Legal range is 2 or more.
- `SAMPLES_PER_BIT`, default 64: samples per transmitted bit. Legal range is 1 or more.
- `GUARD_SAMPLES`, default 16: zero-valued samples appended after each word. 0 is legal.
- `INC0`, default 16'h0400: phase increment per sample for bit 0.
- `INC1`, default 16'h0800: phase increment per sample for bit 1.

Ports:
- `sysclk`  in  1: the single clock; all logic runs on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `data_in`  in  16: word to transmit, MSB first.
- `data_valid`  in  1: `data_in` is valid.
- `data_ready`  out  1: block can accept a word.
- `sig_to_dac`  out  16: signed two's-complement sample, held between strobes.
- `dac_strobe`  out  1: one-cycle pulse marking a new `sig_to_dac` value.
- `bit_out`  out  1: bit currently being modulated; 0 outside SEND.
- `busy`  out  1: high in SEND and GUARD.

## Operation
- States are IDLE, SEND and GUARD.
- **IDLE**
  - `data_ready`=1.
  - On `data_valid && data_ready`, `data_in` is loaded into a 16-bit shift register.
  - The phase accumulator (16 bit), sample divider, sample count and bit count are all cleared.
  - Next state is SEND.
- **Sample tick**
  - The divider counts 0..`CLK_PER_SAMPLE`-1 while in SEND or GUARD.
  - A tick occurs when the divider equals `CLK_PER_SAMPLE`-1.
  - On a tick, `dac_strobe`=1 for that cycle, and the new sample is registered in the same edge.
- **SEND, per tick**
  - `sig_to_dac` <= LUT[phase[15:10]].
  - phase <= phase + (shift[15] ? `INC1` : `INC0`), wrapping mod 2^16.
  - The sample count increments.
  - On the tick where the sample count reaches `SAMPLES_PER_BIT`-1:
    - the sample count clears;
    - the shift register shifts left by 1;
    - the bit count increments.
  - After the last sample of bit 15, next state is GUARD.
- **LUT**
  - 64 entries: LUT[i] = round(32767·sin(2πi/64)).
  - Key values: LUT[0]=0, LUT[16]=32767, LUT[32]=0, LUT[48]=-32767.
  - Combinational ROM.
- **GUARD**
  - Each tick outputs `sig_to_dac`=0 and counts `GUARD_SAMPLES` ticks.
  - Then next state is IDLE. If `GUARD_SAMPLES`=0, go straight to IDLE after SEND.
- **Status outputs**
  - `bit_out` = shift[15] in SEND.
  - The phase is not reset between bits, only at word accept.
- **Reset values**
  - State is IDLE.
  - `data_ready`=1 on the first cycle after reset release.
  - `sig_to_dac`=0, `dac_strobe`=0, `bit_out`=0, `busy`=0.
  - Phase, shift register and all counters are 0.
- **Reset mid-frame** aborts immediately: outputs return to their reset values and the word is discarded.
- `data_valid` while busy is ignored; the source must hold it until `data_ready`.

## Timing
- `data_ready` drops the cycle after accept.
- `busy` rises the cycle after accept.
- The first `dac_strobe` occurs `CLK_PER_SAMPLE` cycles after the accept edge.
- Strobes are exactly `CLK_PER_SAMPLE` cycles apart for the whole frame.
- Frame length is (16·`SAMPLES_PER_BIT` + `GUARD_SAMPLES`)·`CLK_PER_SAMPLE` cycles.
  - With defaults: 16 bits × 64 samples × 4 cycles = 4096, plus 16 × 4 = 64 guard cycles, giving 4160 cycles.
- `data_ready` returns the cycle after the final guard tick, which is also when `busy` falls.
- Back-to-back words: a word presented during the first IDLE cycle is accepted, so the minimum gap between frames is 1 cycle.

## Test plan
- **Reset values:** assert `reset` for 8 cycles, then release.
  - During reset: `data_ready`=0, `sig_to_dac`=0, `dac_strobe`=0, `busy`=0.
  - After release: `data_ready`=1 on the first rising edge.
- **All-zeros word:** send 16'h0000 with defaults.
  - Expect 1024 strobes at 4-cycle spacing.
  - Each bit spans one sine period: samples 0, LUT[1], … with sample 16 = 32767 and sample 48 = -32767.
  - Then 16 zero samples; `busy` falls at cycle 4160.
- **Pattern word:** send 16'h69C3.
  - `bit_out` sequence is 0,1,1,0,1,0,0,1,1,1,0,0,0,0,1,1, each held 256 cycles.
  - Bit-1 intervals show two sine periods, i.e. LUT index step 2.
- **Phase continuity:** set `INC0`=16'h0500 and send 16'hFFFF then 16'h0000.
  - The phase at each bit boundary equals the accumulated sum, with no jump to index 0.
  - The phase resets only at the second word's accept.
- **Handshake:** hold `data_valid`=1 with 16'hEFAB throughout a frame.
  - Exactly one accept occurs per frame.
  - The second accept lands on the first IDLE cycle after guard.
- **Reset mid-operation:** pulse `reset` at cycle 1025 of a frame.
  - Outputs go to reset values asynchronously.
  - `data_ready`=1 after release, and a new word transmits with phase starting at 0.
